// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the multi-cycle CPU control block: FSM state encoding,
// instruction field widths, opcode/opext values, the HALT and NOP words, and
// the decoded-instruction record passed from instr_field_decode to the FSM.
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned OP_W      = 4;

  // FSM states
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd5;

  // Opcodes (instr[15:12])
  localparam logic [OP_W-1:0] OP_REG  = 4'h0;
  localparam logic [OP_W-1:0] OP_ANDI = 4'h1;
  localparam logic [OP_W-1:0] OP_ORI  = 4'h2;
  localparam logic [OP_W-1:0] OP_XORI = 4'h3;
  localparam logic [OP_W-1:0] OP_MEM  = 4'h4;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h5;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h9;
  localparam logic [OP_W-1:0] OP_CMPI = 4'hB;
  localparam logic [OP_W-1:0] OP_MOVI = 4'hD;

  // Opext values (instr[7:4])
  localparam logic [OP_W-1:0] EXT_LOAD = 4'h0;
  localparam logic [OP_W-1:0] EXT_STOR = 4'h4;
  localparam logic [OP_W-1:0] EXT_CMP  = 4'hB;

  // Special whole-word encodings
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;
  localparam logic [INSTR_W-1:0] NOP_WORD  = 16'h0000;

  // Decoded view of one instruction word
  typedef struct packed {
    logic [REG_IDX_W-1:0] rdst_idx;
    logic [REG_IDX_W-1:0] rsrc_idx;
    logic [OP_W-1:0]      alu_op;
    logic                 imm_sel;
    logic [INSTR_W-1:0]   imm;
    logic                 wb_sel;
    logic                 wr_reg;   // ALU result written back in WB
    logic                 is_load;
    logic                 is_stor;
    logic                 is_halt;
  } dec_t;

  // Sign-extend an 8-bit immediate to the datapath width
  function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// ----------------------------------------------------------------------------
// cpu_control_if
// Bundle between the control FSM and the instruction memory / datapath.
//   instr    : instruction word from instruction memory
//   pc_en    : PC increment strobe
//   rdst_idx : destination register index
//   rsrc_idx : source register index
//   reg_we   : register-file write strobe
//   alu_op   : ALU operation code
//   imm_sel  : ALU B operand select (1 = imm)
//   imm      : sign-extended immediate
//   mem_we   : data-memory write strobe
//   wb_sel   : write-back select (1 = data memory)
//   halted   : CPU halted
// master = control block, slave = memory/datapath side.
// ----------------------------------------------------------------------------
interface cpu_control_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0]   instr;
  logic                 pc_en;
  logic [REG_IDX_W-1:0] rdst_idx;
  logic [REG_IDX_W-1:0] rsrc_idx;
  logic                 reg_we;
  logic [OP_W-1:0]      alu_op;
  logic                 imm_sel;
  logic [INSTR_W-1:0]   imm;
  logic                 mem_we;
  logic                 wb_sel;
  logic                 halted;

  modport master (
    input  instr,
    output pc_en, rdst_idx, rsrc_idx, reg_we, alu_op, imm_sel, imm,
           mem_we, wb_sel, halted
  );

  modport slave (
    output instr,
    input  pc_en, rdst_idx, rsrc_idx, reg_we, alu_op, imm_sel, imm,
           mem_we, wb_sel, halted
  );
endinterface

// File: rtl/instr_field_decode.sv
// ----------------------------------------------------------------------------
// instr_field_decode
// Combinational decode of one instruction word into datapath controls and
// instruction-class flags.
//   i_ir  : instruction word
//   o_dec : register indices, alu_op, imm_sel, imm, wb_sel and class flags
// ----------------------------------------------------------------------------
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output dec_t               o_dec
);

  logic [OP_W-1:0] w_opcode;
  logic [OP_W-1:0] w_opext;

  assign w_opcode = i_ir[15:12];
  assign w_opext  = i_ir[7:4];

  // Field extraction and instruction classification
  always_comb begin
    o_dec          = '0;
    o_dec.rdst_idx = i_ir[11:8];
    o_dec.rsrc_idx = i_ir[3:0];
    o_dec.imm      = sext8(i_ir[7:0]);

    // All-zero word is the canonical NOP (e.g. cleared memory), so it must
    // not fall into the register form below.
    if (i_ir == HALT_WORD) begin
      o_dec.is_halt = 1'b1;
    end else if (i_ir != NOP_WORD) begin
      case (w_opcode)
        OP_REG: begin
          o_dec.alu_op  = w_opext;
          o_dec.imm_sel = 1'b0;
          o_dec.wr_reg  = (w_opext != EXT_CMP);
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
          o_dec.alu_op  = w_opcode;
          o_dec.imm_sel = 1'b1;
          o_dec.wr_reg  = (w_opcode != OP_CMPI);
        end
        OP_MEM: begin
          if (w_opext == EXT_LOAD) begin
            o_dec.is_load = 1'b1;
            o_dec.wb_sel  = 1'b1;
          end else if (w_opext == EXT_STOR) begin
            o_dec.is_stor = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control.sv
// ----------------------------------------------------------------------------
// cpu_control
// Multi-cycle, non-overlapped instruction sequencer:
//   FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, HALT on 16'hFFFF.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : cpu_control_if.master (instr in; pc_en, register indices,
//           ALU/immediate controls, write strobes, halted out)
// ----------------------------------------------------------------------------
module cpu_control
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  cpu_control_if.master bus
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_src;
  dec_t               w_dec;
  dec_t               w_dec_out;
  logic               w_pc_en;
  logic               w_reg_we;
  logic               w_mem_we;
  logic               w_halted;

  // instr is only valid during DECODE and IR captures it at the end of that
  // cycle, so DECODE looks at instr directly to keep fields stable DECODE..WB.
  assign w_ir_src = (r_state == ST_DECODE) ? bus.instr : r_ir;

  instr_field_decode u_decode (
    .i_ir  (w_ir_src),
    .o_dec (w_dec)
  );

  // State and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        r_ir <= bus.instr;
      end
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next_state = r_state;
    w_pc_en      = 1'b0;
    w_reg_we     = 1'b0;
    w_mem_we     = 1'b0;
    w_halted     = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_pc_en      = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: w_next_state = w_dec.is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_next_state = (w_dec.is_load || w_dec.is_stor) ? ST_MEM : ST_WB;
      ST_MEM: begin
        w_mem_we     = w_dec.is_stor;
        w_next_state = ST_WB;
      end
      ST_WB: begin
        w_reg_we     = w_dec.wr_reg | w_dec.is_load;
        w_next_state = ST_FETCH;
      end
      ST_HALT:   w_halted = 1'b1;
      default:   w_next_state = ST_FETCH;
    endcase

    // Reset aborts whatever is in flight: no strobe in the reset cycle itself.
    if (reset) begin
      w_pc_en  = 1'b0;
      w_reg_we = 1'b0;
      w_mem_we = 1'b0;
      w_halted = 1'b0;
    end
  end

  // Field outputs at their reset values while reset is held
  assign w_dec_out = reset ? '0 : w_dec;

  assign bus.pc_en    = w_pc_en;
  assign bus.reg_we   = w_reg_we;
  assign bus.mem_we   = w_mem_we;
  assign bus.halted   = w_halted;
  assign bus.rdst_idx = w_dec_out.rdst_idx;
  assign bus.rsrc_idx = w_dec_out.rsrc_idx;
  assign bus.alu_op   = w_dec_out.alu_op;
  assign bus.imm_sel  = w_dec_out.imm_sel;
  assign bus.imm      = w_dec_out.imm;
  assign bus.wb_sel   = w_dec_out.wb_sel;

endmodule

// File: tb/tb_cpu_control.sv
// ----------------------------------------------------------------------------
// tb_cpu_control
// Directed, table-driven bench for cpu_control plus hand-written sequences
// for HALT and reset-in-WB.
// ----------------------------------------------------------------------------
module tb_cpu_control;

  logic clk = 1'b0;
  logic reset;

  cpu_control_if bus ();

  cpu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {rdst, rsrc, alu_op, imm_sel, imm, wb_sel}
  typedef struct {
    logic [15:0] instr;
    logic [29:0] fields;
    logic        we_reg;
    logic        we_mem;
    int          period;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {pc_en, reg_we, mem_we, halted}
  function automatic logic [3:0] strobes();
    return {bus.pc_en, bus.reg_we, bus.mem_we, bus.halted};
  endfunction

  function automatic logic [29:0] fields();
    return {bus.rdst_idx, bus.rsrc_idx, bus.alu_op, bus.imm_sel, bus.imm, bus.wb_sel};
  endfunction

  // Hold reset for two edges, check reset outputs, release just after an edge.
  // Returns inside cycle 1 (the first FETCH).
  task automatic apply_reset(input logic [15:0] w, input string tag);
    bus.instr = w;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " reset strobes"}, 64'(strobes()), 64'(4'b0000));
    check({tag, " reset fields"},  64'(fields()),  64'(30'h0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_s;

    vecs[0]  = '{16'h0000, {4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0}, 1'b0, 1'b0, 4};
    vecs[1]  = '{16'h0A53, {4'hA, 4'h3, 4'h5, 1'b0, 16'h0053, 1'b0}, 1'b1, 1'b0, 4};
    vecs[2]  = '{16'h52FF, {4'h2, 4'hF, 4'h5, 1'b1, 16'hFFFF, 1'b0}, 1'b1, 1'b0, 4};
    vecs[3]  = '{16'h4147, {4'h1, 4'h7, 4'h0, 1'b0, 16'h0047, 1'b0}, 1'b0, 1'b1, 5};
    vecs[4]  = '{16'h4302, {4'h3, 4'h2, 4'h0, 1'b0, 16'h0002, 1'b1}, 1'b1, 1'b0, 5};
    vecs[5]  = '{16'h4240, {4'h2, 4'h0, 4'h0, 1'b0, 16'h0040, 1'b0}, 1'b0, 1'b1, 5};
    vecs[6]  = '{16'h01B2, {4'h1, 4'h2, 4'hB, 1'b0, 16'hFFB2, 1'b0}, 1'b0, 1'b0, 4};
    vecs[7]  = '{16'hB37F, {4'h3, 4'hF, 4'hB, 1'b1, 16'h007F, 1'b0}, 1'b0, 1'b0, 4};
    vecs[8]  = '{16'h1C80, {4'hC, 4'h0, 4'h1, 1'b1, 16'hFF80, 1'b0}, 1'b1, 1'b0, 4};
    vecs[9]  = '{16'h7123, {4'h1, 4'h3, 4'h0, 1'b0, 16'h0023, 1'b0}, 1'b0, 1'b0, 4};
    vecs[10] = '{16'h4A91, {4'hA, 4'h1, 4'h0, 1'b0, 16'hFF91, 1'b0}, 1'b0, 1'b0, 4};
    vecs[11] = '{16'hD501, {4'h5, 4'h1, 4'hD, 1'b1, 16'h0001, 1'b0}, 1'b1, 1'b0, 4};
    vecs[12] = '{16'h9E0C, {4'hE, 4'hC, 4'h9, 1'b1, 16'h000C, 1'b0}, 1'b1, 1'b0, 4};

    bus.instr = 16'h0000;
    reset     = 1'b1;

    // Table: one instruction from reset through the next FETCH
    for (int i = 0; i < NV; i++) begin
      apply_reset(vecs[i].instr, $sformatf("v%0d", i));
      for (int c = 1; c <= vecs[i].period + 1; c++) begin
        @(negedge clk);
        exp_s = {(c == 1) || (c == vecs[i].period + 1),
                 vecs[i].we_reg && (c == vecs[i].period),
                 vecs[i].we_mem && (c == vecs[i].period - 1),
                 1'b0};
        check($sformatf("v%0d %h strobes c%0d", i, vecs[i].instr, c),
              64'(strobes()), 64'(exp_s));
        if (c >= 2 && c <= vecs[i].period)
          check($sformatf("v%0d %h fields c%0d", i, vecs[i].instr, c),
                64'(fields()), 64'(vecs[i].fields));
      end
    end

    // HALT: FETCH, DECODE, then halted with no strobes for 20+ cycles
    apply_reset(16'hFFFF, "halt");
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      exp_s = (c == 1) ? 4'b1000 : (c == 2) ? 4'b0000 : 4'b0001;
      check($sformatf("halt strobes c%0d", c), 64'(strobes()), 64'(exp_s));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("halt in reset", 64'(strobes()), 64'(4'b0000));
    bus.instr = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("halt release pc_en", 64'(strobes()), 64'(4'b1000));

    // Reset arriving in WB aborts the write; a fresh FETCH follows release
    for (int k = 0; k < 2; k++) begin
      logic [15:0] w;
      logic        is_ld;
      w     = (k == 0) ? 16'h4302 : 16'h4240;
      is_ld = (k == 0);
      apply_reset(w, $sformatf("wbrst%0d", k));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("wbrst%0d MEM strobes", k), 64'(strobes()), 64'({2'b00, !is_ld, 1'b0}));
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check($sformatf("wbrst%0d WB strobes", k), 64'(strobes()), 64'(4'b0000));
      check($sformatf("wbrst%0d WB fields", k),  64'(fields()),  64'(30'h0));
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("wbrst%0d held strobes", k), 64'(strobes()), 64'(4'b0000));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check($sformatf("wbrst%0d release strobes", k), 64'(strobes()), 64'(4'b1000));
      check($sformatf("wbrst%0d IR cleared", k),      64'(fields()),  64'(30'h0));
      for (int c = 2; c <= 5; c++) begin
        @(negedge clk);
        exp_s = {1'b0, is_ld && (c == 5), !is_ld && (c == 4), 1'b0};
        check($sformatf("wbrst%0d rerun c%0d", k, c), 64'(strobes()), 64'(exp_s));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
